// File: rtl/axi_pkg.sv
// Shared AXI4 constants and the config-master FSM state encoding.
// Imported by the master and by anything that needs to decode its debug state.
package axi_pkg;

   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Bufferable + modifiable: normal non-cacheable memory attributes.
   localparam logic [3:0] CACHE_MODIFIABLE_BUF = 4'b0011;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WR_REQ  = 3'd1;
   localparam logic [2:0] ST_WR_RESP = 3'd2;
   localparam logic [2:0] ST_RD_REQ  = 3'd3;
   localparam logic [2:0] ST_RD_RESP = 3'd4;

   // SLVERR and DECERR both report an error; OKAY and EXOKAY do not.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return !((resp == RESP_OKAY) || (resp == RESP_EXOKAY));
   endfunction

endpackage

// File: rtl/axi_config_master.sv
// Single-outstanding AXI4 master: turns one register request at a time into a
// single-beat AXI4 write or read and returns a one-cycle completion pulse.
module axi_config_master
   import axi_pkg::*;
#(
   parameter int         ADDR_WIDTH = 32,
   parameter int         DATA_WIDTH = 32,
   parameter int         STRB_WIDTH = DATA_WIDTH / 8,
   parameter int         ID_WIDTH   = 8,
   parameter int         AXI_ID     = 0,
   parameter logic [2:0] AXI_PROT   = 3'b000
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [STRB_WIDTH-1:0] req_wstrb,

   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,

   output logic [ID_WIDTH-1:0]   m_axi_awid,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [7:0]            m_axi_awlen,
   output logic [2:0]            m_axi_awsize,
   output logic [1:0]            m_axi_awburst,
   output logic                  m_axi_awlock,
   output logic [3:0]            m_axi_awcache,
   output logic [2:0]            m_axi_awprot,
   output logic [3:0]            m_axi_awqos,
   output logic [3:0]            m_axi_awregion,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,

   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic [STRB_WIDTH-1:0] m_axi_wstrb,
   output logic                  m_axi_wlast,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,

   input  logic [ID_WIDTH-1:0]   m_axi_bid,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,

   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic [3:0]            m_axi_arqos,
   output logic [3:0]            m_axi_arregion,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,

   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,

   output logic [2:0]            dbg_state
);

   localparam logic [2:0]          AXI_SIZE = 3'($clog2(STRB_WIDTH));
   localparam logic [ID_WIDTH-1:0] ID_VAL   = ID_WIDTH'(AXI_ID);

   // Handshake rule on every channel: a transfer happens on a rising edge where
   // valid && ready; once valid is raised it stays high, with its payload
   // unchanged, until that edge. rsp_valid is a pulse with no back-pressure.
   logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic [2:0]            state;
   logic                  ready_q;
   logic                  aw_done, w_done;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic                  unused_rlast;

   assign aw_hs = m_axi_awvalid & m_axi_awready;
   assign w_hs  = m_axi_wvalid  & m_axi_wready;
   assign b_hs  = m_axi_bvalid  & m_axi_bready;
   assign ar_hs = m_axi_arvalid & m_axi_arready;
   assign r_hs  = m_axi_rvalid  & m_axi_rready;

   // Every burst is a single beat, so rlast carries no information.
   assign unused_rlast = m_axi_rlast;

   assign m_axi_awid     = ID_VAL;
   assign m_axi_awaddr   = addr_q;
   assign m_axi_awlen    = 8'd0;
   assign m_axi_awsize   = AXI_SIZE;
   assign m_axi_awburst  = BURST_INCR;
   assign m_axi_awlock   = 1'b0;
   assign m_axi_awcache  = CACHE_MODIFIABLE_BUF;
   assign m_axi_awprot   = AXI_PROT;
   assign m_axi_awqos    = 4'd0;
   assign m_axi_awregion = 4'd0;

   assign m_axi_wdata    = wdata_q;
   assign m_axi_wstrb    = wstrb_q;
   assign m_axi_wlast    = 1'b1;

   assign m_axi_arid     = ID_VAL;
   assign m_axi_araddr   = addr_q;
   assign m_axi_arlen    = 8'd0;
   assign m_axi_arsize   = AXI_SIZE;
   assign m_axi_arburst  = BURST_INCR;
   assign m_axi_arlock   = 1'b0;
   assign m_axi_arcache  = CACHE_MODIFIABLE_BUF;
   assign m_axi_arprot   = AXI_PROT;
   assign m_axi_arqos    = 4'd0;
   assign m_axi_arregion = 4'd0;

   // ready_q comes out of reset set; masking with rst keeps the request port
   // closed while reset is held and open on the first cycle after release.
   assign req_ready = ready_q & ~rst;
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         ready_q       <= 1'b1;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_err       <= 1'b0;
         rsp_rdata     <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         case (state)
            ST_IDLE: begin
               // After a completion, hold the port closed for the pulse cycle.
               if (!ready_q) begin
                  ready_q <= 1'b1;
               end else if (req_valid) begin
                  ready_q <= 1'b0;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  wstrb_q <= req_wstrb;
                  if (req_we) begin
                     m_axi_awvalid <= 1'b1;
                     m_axi_wvalid  <= 1'b1;
                     state         <= ST_WR_REQ;
                  end else begin
                     m_axi_arvalid <= 1'b1;
                     state         <= ST_RD_REQ;
                  end
               end
            end
            ST_WR_REQ: begin
               if (aw_hs) begin
                  m_axi_awvalid <= 1'b0;
                  aw_done       <= 1'b1;
               end
               if (w_hs) begin
                  m_axi_wvalid <= 1'b0;
                  w_done       <= 1'b1;
               end
               // AW and W may complete in either order or on the same edge.
               if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                  aw_done      <= 1'b0;
                  w_done       <= 1'b0;
                  m_axi_bready <= 1'b1;
                  state        <= ST_WR_RESP;
               end
            end
            ST_WR_RESP: begin
               if (b_hs) begin
                  m_axi_bready <= 1'b0;
                  rsp_valid    <= 1'b1;
                  rsp_err      <= resp_is_err(m_axi_bresp) | (m_axi_bid != ID_VAL);
                  state        <= ST_IDLE;
               end
            end
            ST_RD_REQ: begin
               if (ar_hs) begin
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b1;
                  state         <= ST_RD_RESP;
               end
            end
            ST_RD_RESP: begin
               if (r_hs) begin
                  m_axi_rready <= 1'b0;
                  rsp_valid    <= 1'b1;
                  rsp_rdata    <= m_axi_rdata;
                  rsp_err      <= resp_is_err(m_axi_rresp) | (m_axi_rid != ID_VAL);
                  state        <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_config_master.sv
// Bench for axi_config_master: a stallable AXI slave with its own memory, a
// request-level reference model with an expected-response queue, and directed tests.
module tb_axi_config_master;
   import axi_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int IW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0, req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [SW-1:0] req_wstrb = '0;
   logic          req_ready, rsp_valid, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic [IW-1:0] awid, arid;
   logic [AW-1:0] awaddr, araddr;
   logic [7:0]    awlen, arlen;
   logic [2:0]    awsize, arsize, awprot, arprot;
   logic [1:0]    awburst, arburst;
   logic          awlock, arlock, awvalid, arvalid, wlast, wvalid, bready, rready;
   logic [3:0]    awcache, arcache, awqos, arqos, awregion, arregion;
   logic [DW-1:0] wdata;
   logic [SW-1:0] wstrb;
   logic          awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0, rlast = 0;
   logic [IW-1:0] bid = '0, rid = '0;
   logic [1:0]    bresp = '0, rresp = '0;
   logic [DW-1:0] rdata = '0;
   logic [2:0]    dbg_state;

   axi_config_master dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
      .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
      .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awregion(awregion),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
      .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
      .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arregion(arregion),
      .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
      .m_axi_rvalid(rvalid), .m_axi_rready(rready),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int failures = 0;
   logic [DW:0]   exp_q[$];      // {err, rdata}
   logic [DW:0]   exp_e;
   logic [DW-1:0] ref_mem[logic [AW-1:0]];
   logic [DW-1:0] smem[logic [AW-1:0]];
   int            in_flight = 0;
   int            acc_cyc = 0, rsp_cyc = 0, b_hs_count = 0;
   logic [DW-1:0] last_rdata = '0;
   logic          last_err = 1'b0, rdy_at_rsp = 1'b0;
   logic [AW-1:0] cur_addr = '0;
   logic [DW-1:0] cur_wdata = '0;
   logic [SW-1:0] cur_strb = '0;

   // slave knobs
   int         aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
   logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   logic [7:0] bid_cfg = 8'h00, rid_cfg = 8'h00;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=handshake", name);
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                           input logic [SW-1:0] strb);
      logic [DW-1:0] r;
      r = old;
      for (int i = 0; i < SW; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   // ---------------- AXI slave ----------------
   initial begin : slave
      logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
      logic got_aw, got_w, b_pend, r_pend;
      int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
      logic [AW-1:0] wa, pa_aw, pa_ar;
      logic [DW-1:0] wd, pd_w, rd_word, old;
      logic [SW-1:0] ws, ps_w;
      logic pv_aw, pv_w, pv_ar;
      got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      pv_aw = 0; pv_w = 0; pv_ar = 0;
      wa = '0; wd = '0; ws = '0; rd_word = '0; pa_aw = '0; pa_ar = '0; pd_w = '0; ps_w = '0;
      forever begin
         @(posedge clk);
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         b_hs  = bvalid && bready;
         ar_hs = arvalid && arready;
         r_hs  = rvalid && rready;
         if (rst) begin
            got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            pv_aw = 0; pv_w = 0; pv_ar = 0;
         end else begin
            if (pv_aw) check("aw_stable", {awvalid, awaddr}, {1'b1, pa_aw});
            if (pv_w)  check("w_stable", {wvalid, wstrb, wdata}, {1'b1, ps_w, pd_w});
            if (pv_ar) check("ar_stable", {arvalid, araddr}, {1'b1, pa_ar});
            if ((awvalid || wvalid || bready) && (arvalid || rready))
               check("one_in_flight", 1'b1, 1'b0);
            pv_aw = awvalid && !aw_hs; pa_aw = awaddr;
            pv_w  = wvalid && !w_hs;   pd_w = wdata; ps_w = wstrb;
            pv_ar = arvalid && !ar_hs; pa_ar = araddr;
            if (aw_hs) begin
               check("aw_addr", awaddr, cur_addr);
               check("aw_attr", {awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion},
                     {8'h00, 8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0, 4'h0});
               got_aw = 1; wa = awaddr;
            end
            if (w_hs) begin
               check("w_beat", {wlast, wstrb, wdata}, {1'b1, cur_strb, cur_wdata});
               got_w = 1; wd = wdata; ws = wstrb;
            end
            if (ar_hs) begin
               check("ar_addr", araddr, cur_addr);
               check("ar_attr", {arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion},
                     {8'h00, 8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0, 4'h0});
               rd_word = smem.exists(araddr) ? smem[araddr] : '0;
               r_pend = 1; r_cnt = 0;
            end
            if (b_hs) begin b_pend = 0; b_hs_count++; end
            if (r_hs) r_pend = 0;
            if (b_pend && !bvalid) b_cnt++;
            if (r_pend && !rvalid && !ar_hs) r_cnt++;
            if (got_aw && got_w) begin
               old = smem.exists(wa) ? smem[wa] : '0;
               smem[wa] = merge(old, wd, ws);
               got_aw = 0; got_w = 0; b_pend = 1; b_cnt = 0;
            end
            aw_cnt = (awvalid && !aw_hs) ? aw_cnt + 1 : 0;
            w_cnt  = (wvalid && !w_hs) ? w_cnt + 1 : 0;
            ar_cnt = (arvalid && !ar_hs) ? ar_cnt + 1 : 0;
         end
         #1;
         awready = !rst && awvalid && (aw_cnt >= aw_dly);
         wready  = !rst && wvalid && (w_cnt >= w_dly);
         arready = !rst && arvalid && (ar_cnt >= ar_dly);
         bvalid  = !rst && b_pend && (b_cnt >= b_dly);
         bresp   = bresp_cfg;
         bid     = bid_cfg;
         rvalid  = !rst && r_pend && (r_cnt >= r_dly);
         rresp   = rresp_cfg;
         rid     = rid_cfg;
         rdata   = rvalid ? rd_word : '0;
         rlast   = rvalid;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (rsp_valid) begin
            rsp_cyc    = cyc;
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            rdy_at_rsp = req_ready;
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 1'b1, 1'b0);
            end else begin
               exp_e = exp_q.pop_front();
               check("rsp_rdata", rsp_rdata, exp_e[DW-1:0]);
               check("rsp_err", rsp_err, exp_e[DW]);
            end
            if (in_flight > 0) in_flight--;
         end else begin
            check("rsp_quiet", {rsp_err, rsp_rdata}, '0);
         end
         if (in_flight > 0) check("req_ready_busy", req_ready, 1'b0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [SW-1:0] strb);
      int n;
      logic [DW-1:0] old;
      n = 0;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; req_wstrb = strb;
      @(posedge clk);
      while (!req_ready && n < 200) begin
         n++;
         @(posedge clk);
      end
      if (!req_ready) begin
         fail_timeout("req_accept");
      end else begin
         acc_cyc   = cyc;
         cur_addr  = addr; cur_wdata = data; cur_strb = strb;
         old = ref_mem.exists(addr) ? ref_mem[addr] : '0;
         if (we) begin
            ref_mem[addr] = merge(old, data, strb);
            exp_q.push_back({bresp_cfg[1] | (bid_cfg != 8'h00), {DW{1'b0}}});
         end else begin
            exp_q.push_back({rresp_cfg[1] | (rid_cfg != 8'h00), old});
         end
         in_flight++;
      end
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (in_flight != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (in_flight != 0) begin
         fail_timeout("rsp_wait");
         in_flight = 0;
         exp_q.delete();
      end
   endtask

   task automatic set_delays(input int a, input int w, input int ar, input int b, input int r);
      aw_dly = a; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r;
   endtask

   // ---------------- directed tests ----------------
   initial begin : main
      int bh;
      repeat (3) @(negedge clk);
      check("rst_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata, awvalid, wvalid, bready, arvalid, rready},
            '0);
      check("rst_state", dbg_state, ST_IDLE);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", req_ready, 1'b1);

      // 1: zero-wait write
      do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      @(negedge clk);
      check("t1_aw_w_valid", {awvalid, wvalid, req_ready}, 3'b110);
      wait_done();
      check("t1_latency", rsp_cyc - acc_cyc, 3);
      check("t1_err", last_err, 1'b0);

      // 2: read back
      do_req(1'b0, 32'h10, 32'h0, 4'h0);
      @(negedge clk);
      check("t2_arvalid", {arvalid, awvalid, req_ready}, 3'b100);
      wait_done();
      check("t2_rdata", last_rdata, 32'hDEADBEEF);
      check("t2_latency", rsp_cyc - acc_cyc, 3);
      check("t2_ready_at_rsp", rdy_at_rsp, 1'b0);
      @(negedge clk);
      check("t2_ready_after", req_ready, 1'b1);

      // 3: W stalled 5 cycles behind AW
      set_delays(0, 5, 0, 0, 0);
      bh = b_hs_count;
      do_req(1'b1, 32'h18, 32'hCAFEF00D, 4'hF);
      @(negedge clk);
      check("t3_c1", {awvalid, wvalid}, 2'b11);
      @(negedge clk);
      check("t3_c2", {awvalid, wvalid}, 2'b01);
      wait_done();
      check("t3_latency", rsp_cyc - acc_cyc, 8);
      check("t3_b_count", b_hs_count - bh, 1);
      set_delays(0, 0, 0, 0, 0);

      // 4: error responses
      bresp_cfg = 2'b11;
      do_req(1'b1, 32'h14, 32'h0BADF00D, 4'hF);
      wait_done();
      check("t4_werr", last_err, 1'b1);
      bresp_cfg = 2'b00; rresp_cfg = 2'b10;
      do_req(1'b0, 32'h14, 32'h0, 4'h0);
      wait_done();
      check("t4_rerr", {last_err, last_rdata}, {1'b1, 32'h0BADF00D});
      rresp_cfg = 2'b01;
      do_req(1'b0, 32'h10, 32'h0, 4'h0);
      wait_done();
      check("t4_exokay", {last_err, last_rdata}, {1'b0, 32'hDEADBEEF});
      rresp_cfg = 2'b00; bid_cfg = 8'h05;
      do_req(1'b1, 32'h1C, 32'h12345678, 4'hF);
      wait_done();
      check("t4_bid", last_err, 1'b1);
      bid_cfg = 8'h00;

      // strobe merge, pinned by hand
      do_req(1'b1, 32'h20, 32'h11223344, 4'hF);
      do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'h5);
      do_req(1'b0, 32'h20, 32'h0, 4'h0);
      wait_done();
      check("strb_merge", last_rdata, 32'h11BB33DD);

      // 5: reset while in WR_RESP with bvalid up
      do_req(1'b1, 32'h40, 32'h55AA55AA, 4'hF);
      @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      in_flight = 0;
      @(negedge clk);
      check("t5_pre", {dbg_state, bvalid, bready}, {ST_WR_RESP, 2'b11});
      @(negedge clk);
      check("t5_rst", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, req_ready}, '0);
      check("t5_state", dbg_state, ST_IDLE);
      rst = 1'b0;
      @(negedge clk);
      check("t5_ready", req_ready, 1'b1);

      // 6: back-to-back random traffic with random stalls
      for (int i = 0; i < 16; i++) begin
         set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
         do_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) << 2, $urandom,
                4'($urandom_range(1, 15)));
      end
      wait_done();
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #200000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
